// File: rtl/maf_param.sv
// ----------------------------------------------------------------------------
// maf_param -- run-time parametrised moving-average filter
//
// Keeps the last 2**LOG2_NMAX accepted samples in a shift register and
// maintains a running sum over the newest N = 2**win_q of them, together with
// the truncated mean (sum >> win_q) and a flag that says the window has been
// completely filled since the last flush.
//
// Parameters
//   DW         input sample width (unsigned)
//   LOG2_NMAX  log2 of the maximum window / history depth (1..7)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high; overrides every other input
//   clear       synchronous flush of history, sum and fill count
//   win_sel     requested window exponent, clamped to LOG2_NMAX
//   din_valid   din is accepted on this edge when high (and no flush)
//   din         unsigned sample
//   dout_valid  one-cycle pulse on the edge after an accept
//   dout_sum    sum of the last N accepted samples
//   dout_avg    dout_sum >> log2(N), truncating
//   filled      at least N samples accepted since the last flush
// ----------------------------------------------------------------------------
module maf_param #(
    parameter int DW        = 5,
    parameter int LOG2_NMAX = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [2:0]              win_sel,
    input  logic                    din_valid,
    input  logic [DW-1:0]           din,
    output logic                    dout_valid,
    output logic [DW+LOG2_NMAX-1:0] dout_sum,
    output logic [DW-1:0]           dout_avg,
    output logic                    filled
);

    localparam int NMAX = 2 ** LOG2_NMAX;
    localparam int SW   = DW + LOG2_NMAX;   // sum width, never overflows
    localparam int CW   = LOG2_NMAX + 1;    // count must reach NMAX itself

    logic [DW-1:0] hist [NMAX];
    logic [2:0]    win_q;
    logic [CW-1:0] count;

    logic [2:0]    win_c;
    logic          flush;
    logic          accept;
    logic [CW-1:0] n_win;
    logic [DW-1:0] tap;
    logic [SW-1:0] sum_next;
    logic [CW-1:0] count_next;

    // ------------------------------------------------------------------------
    // Next-state arithmetic. dout_sum doubles as the running sum: after an
    // accept both equal sum_next, on a flush both are zero and when idle both
    // hold, so a separate accumulator would always carry the same value.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment so no path leaves it unassigned (no inferred latch).
        tap = '0;

        win_c  = (win_sel > 3'(LOG2_NMAX)) ? 3'(LOG2_NMAX) : win_sel;
        // A change of the clamped window is treated exactly like clear: the
        // old history belongs to a different window length.
        flush  = clear || (win_c != win_q);
        accept = din_valid && !flush;
        n_win  = CW'(1) << win_q;

        // Departing tap h[N-1], read before the shift.
        for (int k = 0; k <= LOG2_NMAX; k++) begin
            if (win_q == 3'(k)) begin
                tap = hist[(1 << k) - 1];
            end
        end

        // Modular in SW bits: the final result always fits because the
        // departing tap is part of the current sum.
        sum_next   = dout_sum + SW'(din) - SW'(tap);
        count_next = (count < n_win) ? count + CW'(1) : count;
    end

    // ------------------------------------------------------------------------
    // State and registered outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, which the shift relies on.
        if (reset) begin
            // NOTE: the history array is reset explicitly because empty slots
            // must read as zero for partial-window sums to be correct.
            for (int i = 0; i < NMAX; i++) begin
                hist[i] <= '0;
            end
            win_q      <= '0;
            count      <= '0;
            dout_valid <= 1'b0;
            dout_sum   <= '0;
            dout_avg   <= '0;
            filled     <= 1'b0;
        end else if (flush) begin
            for (int i = 0; i < NMAX; i++) begin
                hist[i] <= '0;
            end
            win_q      <= win_c;
            count      <= '0;
            dout_valid <= 1'b0;
            dout_sum   <= '0;
            dout_avg   <= '0;
            filled     <= 1'b0;
        end else begin
            dout_valid <= accept;
            if (accept) begin
                for (int i = NMAX - 1; i > 0; i--) begin
                    hist[i] <= hist[i-1];
                end
                hist[0]  <= din;
                dout_sum <= sum_next;
                // sum_next <= N*(2**DW-1), so the shifted value fits DW bits.
                dout_avg <= DW'(sum_next >> win_q);
                count    <= count_next;
                filled   <= (count_next >= n_win);
            end
        end
    end

endmodule
